// File: rtl/dma_mc_pkg.sv
// dma_mc_pkg
// Shared types and helpers for the multi-channel sample DMA.
//   state_t      : transfer FSM states (IDLE/REQ/READ/WRITE)
//   clog2        : ceiling log2 usable in parameter expressions
//   compose_addr : ping-pong RAM address for a channel/half/index triple
package dma_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Each channel owns a 2*depth region: lower half first, upper half second.
    function automatic int unsigned compose_addr(input int unsigned ch,
                                                 input logic        half,
                                                 input int unsigned idx,
                                                 input int unsigned depth);
        int unsigned base;
        base = ch * 2 * depth;
        if (half) begin
            base = base + depth;
        end
        return base + idx;
    endfunction

endpackage

// File: rtl/dma_mc_rr_pick.sv
// dma_mc_rr_pick
// Combinational round-robin picker.
//   pending : per-channel request bits
//   last    : index of the channel served most recently
//   valid   : at least one channel is pending
//   sel     : first pending channel found searching from (last + 1) mod NCH
module dma_mc_rr_pick #(
    parameter int NCH = 2,
    parameter int SW  = 1
) (
    input  logic [NCH-1:0] pending,
    input  logic [SW-1:0]  last,
    output logic           valid,
    output logic [SW-1:0]  sel
);

    logic [SW-1:0] cand;

    // Walk the candidates from farthest to nearest so the nearest pending
    // channel after 'last' is the one left standing in 'sel'.
    always_comb begin
        valid = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = SW'((32'(last) + 32'(k)) % 32'(NCH));
            if (pending[cand]) begin
                valid = 1'b1;
                sel   = cand;
            end
        end
    end

endmodule

// File: rtl/dma_mc.sv
// dma_mc
// Multi-channel sample DMA: collects per-channel sample flags, picks a
// channel round-robin, requests the sample RAM bus, strobes the channel's
// SPI read and writes the sample into that channel's ping-pong region.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   dflag           : per-channel one-cycle "sample ready" pulse
//   read_spi        : one-hot one-cycle read strobe to the selected SPI
//   breq / bgrant   : bus request / grant handshake with the arbiter
//   a, as, write    : RAM address, address strobe, write strobe
//   top_buf_flag    : per-channel half currently being filled
//   buf_done        : per-channel pulse when a half-buffer fills
//   overrun         : per-channel sticky dropped-sample flag
//   clear_overrun   : clears all overrun bits
module dma_mc
    import dma_mc_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int BUF_DEPTH = 64,
    parameter int AW        = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] dflag,
    output logic [NCH-1:0] read_spi,
    output logic           breq,
    input  logic           bgrant,
    output logic [AW-1:0]  a,
    output logic           as,
    output logic           write,
    output logic [NCH-1:0] top_buf_flag,
    output logic [NCH-1:0] buf_done,
    output logic [NCH-1:0] overrun,
    input  logic           clear_overrun
);

    localparam int IW = clog2(BUF_DEPTH);
    localparam int SW = (NCH > 1) ? clog2(NCH) : 1;

    generate
        if (NCH < 1 || NCH > 8) begin : g_bad_nch
            $error("dma_mc: NCH must be in 1..8");
        end
        if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("dma_mc: BUF_DEPTH must be a power of two >= 2");
        end
        if ((1 << AW) < NCH * 2 * BUF_DEPTH) begin : g_bad_aw
            $error("dma_mc: AW too small for NCH*2*BUF_DEPTH");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic [SW-1:0]           last_q, last_d;
    logic [NCH-1:0]          pending_q, pending_d;
    logic [NCH-1:0]          half_q, half_d;
    logic [NCH-1:0]          overrun_q, overrun_d;
    logic [NCH-1:0][IW-1:0]  idx_q, idx_d;
    logic                    breq_q, breq_d;
    logic                    as_q, as_d;
    logic                    write_q, write_d;
    logic [NCH-1:0]          read_spi_q, read_spi_d;
    logic [NCH-1:0]          buf_done_q, buf_done_d;
    logic [AW-1:0]           a_q, a_d;

    logic                    pick_valid;
    logic [SW-1:0]           pick_sel;
    logic [NCH-1:0]          sel_onehot;
    logic                    sel_at_end;

    dma_mc_rr_pick #(
        .NCH (NCH),
        .SW  (SW)
    ) u_rr_pick (
        .pending (pending_q),
        .last    (last_q),
        .valid   (pick_valid),
        .sel     (pick_sel)
    );

    assign sel_onehot = NCH'(1) << sel_q;
    assign sel_at_end = (idx_q[sel_q] == IW'(BUF_DEPTH - 1));

    // Transfer FSM plus the registered bus/strobe outputs. Outputs are
    // derived from the next state so they line up with the state register.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_REQ;
                    sel_d   = pick_sel;
                    last_d  = pick_sel;
                end
            end
            ST_REQ: begin
                if (bgrant) begin
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        breq_d     = (state_d != ST_IDLE);
        read_spi_d = (state_d == ST_READ) ? sel_onehot : '0;
        as_d       = (state_d == ST_WRITE);
        write_d    = (state_d == ST_WRITE);
        buf_done_d = (state_d == ST_WRITE && sel_at_end) ? sel_onehot : '0;
        a_d        = a_q;
        if (state_d == ST_WRITE) begin
            a_d = AW'(compose_addr(32'(sel_q), half_q[sel_q],
                                   32'(idx_q[sel_q]), 32'(BUF_DEPTH)));
        end
    end

    // Per-channel bookkeeping. read_spi_q is high exactly for the channel
    // being read this cycle, which is when its pending bit is consumed; a
    // new flag in that same cycle re-arms pending instead of overrunning.
    always_comb begin
        pending_d = dflag | (pending_q & ~read_spi_q);
        overrun_d = (overrun_q & ~{NCH{clear_overrun}})
                  | (dflag & pending_q & ~read_spi_q);
        idx_d     = idx_q;
        half_d    = half_q;
        if (state_q == ST_WRITE) begin
            idx_d[sel_q] = idx_q[sel_q] + IW'(1);
            if (sel_at_end) begin
                half_d[sel_q] = ~half_q[sel_q];
            end
        end
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            last_q     <= SW'(NCH - 1);
            pending_q  <= '0;
            half_q     <= '0;
            overrun_q  <= '0;
            idx_q      <= '0;
            breq_q     <= 1'b0;
            as_q       <= 1'b0;
            write_q    <= 1'b0;
            read_spi_q <= '0;
            buf_done_q <= '0;
            a_q        <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            half_q     <= half_d;
            overrun_q  <= overrun_d;
            idx_q      <= idx_d;
            breq_q     <= breq_d;
            as_q       <= as_d;
            write_q    <= write_d;
            read_spi_q <= read_spi_d;
            buf_done_q <= buf_done_d;
            a_q        <= a_d;
        end
    end

    assign read_spi     = read_spi_q;
    assign breq         = breq_q;
    assign a            = a_q;
    assign as           = as_q;
    assign write        = write_q;
    assign top_buf_flag = half_q;
    assign buf_done     = buf_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_dma_mc.sv
// tb_dma_mc
// Self-checking bench for dma_mc: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_dma_mc;

    localparam int NCH   = 2;
    localparam int DEPTH = 64;
    localparam int AW    = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] dflag;
    logic [NCH-1:0] read_spi;
    logic           breq;
    logic           bgrant;
    logic [AW-1:0]  a;
    logic           as;
    logic           write;
    logic [NCH-1:0] top_buf_flag;
    logic [NCH-1:0] buf_done;
    logic [NCH-1:0] overrun;
    logic           clear_overrun;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    // Reference model: a transaction advances through stages
    // 0 = idle, 1 = waiting for grant, 2 = reading, 3 = writing.
    int             m_stage;
    int             m_ch;
    int             m_last;
    int             m_a;
    int             m_idx [NCH];
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_half;
    logic [NCH-1:0] m_ovr;

    int             wrAddr [$];
    int             wrCyc  [$];
    logic [NCH-1:0] wrDone [$];
    logic [NCH-1:0] wrTop  [$];

    dma_mc #(
        .NCH       (NCH),
        .BUF_DEPTH (DEPTH),
        .AW        (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dflag         (dflag),
        .read_spi      (read_spi),
        .breq          (breq),
        .bgrant        (bgrant),
        .a             (a),
        .as            (as),
        .write         (write),
        .top_buf_flag  (top_buf_flag),
        .buf_done      (buf_done),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic modelStep(input logic [NCH-1:0] df, input logic gnt,
                             input logic clr, input logic rst);
        logic [NCH-1:0] oldPend;
        logic [NCH-1:0] served;
        int pick;
        if (rst) begin
            m_stage = 0;
            m_ch    = 0;
            m_last  = NCH - 1;
            m_a     = 0;
            m_pend  = '0;
            m_half  = '0;
            m_ovr   = '0;
            for (int c = 0; c < NCH; c++) m_idx[c] = 0;
        end else begin
            oldPend = m_pend;
            served  = '0;
            if (m_stage == 2) served[m_ch] = 1'b1;
            m_ovr  = (clr ? '0 : m_ovr) | (df & oldPend & ~served);
            m_pend = df | (oldPend & ~served);
            case (m_stage)
                0: begin
                    pick = -1;
                    for (int k = 1; k <= NCH; k++) begin
                        if (pick < 0 && oldPend[(m_last + k) % NCH]) pick = (m_last + k) % NCH;
                    end
                    if (pick >= 0) begin
                        m_ch    = pick;
                        m_last  = pick;
                        m_stage = 1;
                    end
                end
                1: if (gnt) m_stage = 2;
                2: begin
                    m_a     = m_ch * 2 * DEPTH + (m_half[m_ch] ? DEPTH : 0) + m_idx[m_ch];
                    m_stage = 3;
                end
                default: begin
                    if (m_idx[m_ch] == DEPTH - 1) begin
                        m_idx[m_ch]  = 0;
                        m_half[m_ch] = ~m_half[m_ch];
                    end else begin
                        m_idx[m_ch] = m_idx[m_ch] + 1;
                    end
                    m_stage = 0;
                end
            endcase
        end
    endtask

    task automatic checkAgainstModel();
        logic [NCH-1:0] oh;
        oh = '0;
        oh[m_ch] = 1'b1;
        checkOutput("breq",     32'(breq),         32'(m_stage != 0));
        checkOutput("read_spi", 32'(read_spi),     32'((m_stage == 2) ? oh : '0));
        checkOutput("write",    32'(write),        32'(m_stage == 3));
        checkOutput("as",       32'(as),           32'(m_stage == 3));
        checkOutput("a",        32'(a),            32'(m_a));
        checkOutput("buf_done", 32'(buf_done),
                    32'((m_stage == 3 && m_idx[m_ch] == DEPTH - 1) ? oh : '0));
        checkOutput("top_buf",  32'(top_buf_flag), 32'(m_half));
        checkOutput("overrun",  32'(overrun),      32'(m_ovr));
    endtask

    // One clock cycle: drive inputs at the falling edge, step the model,
    // then compare at the next falling edge and log any write.
    task automatic applyStimulus(input logic [NCH-1:0] df, input logic gnt,
                                 input logic clr, input logic rst);
        dflag         = df;
        bgrant        = gnt;
        clear_overrun = clr;
        reset         = rst;
        modelStep(df, gnt, clr, rst);
        @(negedge clk);
        cyc++;
        checkAgainstModel();
        if (write === 1'b1) begin
            wrAddr.push_back(int'(a));
            wrCyc.push_back(cyc);
            wrDone.push_back(buf_done);
            wrTop.push_back(top_buf_flag);
        end
    endtask

    task automatic sendSample(input int ch, input int gap);
        logic [NCH-1:0] df;
        df = '0;
        df[ch] = 1'b1;
        applyStimulus(df, 1'b1, 1'b0, 1'b0);
        repeat (gap - 1) applyStimulus('0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrCyc.delete();
        wrDone.delete();
        wrTop.delete();
    endtask

    task automatic resetDut();
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        clearLog();
    endtask

    function automatic int wrAt(input int i);
        return (i < wrAddr.size()) ? wrAddr[i] : -1;
    endfunction

    function automatic int topAt(input int i);
        return (i < wrTop.size()) ? int'(wrTop[i]) : -1;
    endfunction

    function automatic int doneAt(input int i);
        return (i < wrDone.size()) ? int'(wrDone[i]) : -1;
    endfunction

    initial begin
        logic [NCH-1:0] df;
        logic           gnt, clr, rst;

        // Reset values
        resetDut();
        checkOutput("rst_breq",     32'(breq),         32'd0);
        checkOutput("rst_write",    32'(write),        32'd0);
        checkOutput("rst_read_spi", 32'(read_spi),     32'd0);
        checkOutput("rst_a",        32'(a),            32'd0);
        checkOutput("rst_overrun",  32'(overrun),      32'd0);
        checkOutput("rst_top",      32'(top_buf_flag), 32'd0);

        // Single sample latency
        resetDut();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("single_breq_c2", 32'(breq), 32'd1);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("single_read_c3", 32'(read_spi), 32'h1);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("single_write_c4", 32'(write), 32'd1);
        checkOutput("single_as_c4",    32'(as),    32'd1);
        checkOutput("single_a_c4",     32'(a),     32'h00);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("single_breq_c5", 32'(breq), 32'd0);

        // Fairness: both channels flag together
        resetDut();
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        repeat (12) applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("fair_count", 32'(wrAddr.size()), 32'd2);
        checkOutput("fair_a0",    32'(wrAt(0)), 32'h00);
        checkOutput("fair_a1",    32'(wrAt(1)), 32'h80);
        if (wrCyc.size() >= 2) checkOutput("fair_gap", 32'(wrCyc[1] - wrCyc[0]), 32'd4);

        // Flag arriving in the read cycle re-arms pending without overrun
        resetDut();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (8) applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("setclr_overrun", 32'(overrun), 32'd0);
        checkOutput("setclr_count",   32'(wrAddr.size()), 32'd2);
        checkOutput("setclr_a1",      32'(wrAt(1)), 32'h01);

        // Half-buffer wrap on channel 1
        resetDut();
        repeat (65) sendSample(1, 6);
        checkOutput("wrap1_a63",    32'(wrAt(63)),   32'hBF);
        checkOutput("wrap1_done63", 32'(doneAt(63)), 32'h2);
        checkOutput("wrap1_done62", 32'(doneAt(62)), 32'h0);
        checkOutput("wrap1_top63",  32'(topAt(63)),  32'h0);
        checkOutput("wrap1_top64",  32'(topAt(64)),  32'h2);
        checkOutput("wrap1_a64",    32'(wrAt(64)),   32'hC0);

        // Full wrap on channel 0
        resetDut();
        repeat (129) sendSample(0, 6);
        checkOutput("wrap0_a64",   32'(wrAt(64)),  32'h40);
        checkOutput("wrap0_top64", 32'(topAt(64)), 32'h1);
        checkOutput("wrap0_a127",  32'(wrAt(127)), 32'h7F);
        checkOutput("wrap0_a128",  32'(wrAt(128)), 32'h00);
        checkOutput("wrap0_top128",32'(topAt(128)),32'h0);

        // Overrun with grant withheld
        resetDut();
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_set",  32'(overrun), 32'h1);
        checkOutput("ovr_breq", 32'(breq),    32'd1);
        repeat (10) applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_writes", 32'(wrAddr.size()), 32'd1);
        checkOutput("ovr_sticky", 32'(overrun), 32'h1);
        applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
        checkOutput("ovr_cleared", 32'(overrun), 32'h0);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0);
        checkOutput("ovr_set_wins", 32'(overrun), 32'h1);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("ovr_clear_again", 32'(overrun), 32'h0);

        // Reset while reading
        resetDut();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst_in_read", 32'(read_spi), 32'h1);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("midrst_breq",     32'(breq),     32'd0);
        checkOutput("midrst_read_spi", 32'(read_spi), 32'd0);
        checkOutput("midrst_write",    32'(write),    32'd0);
        checkOutput("midrst_as",       32'(as),       32'd0);
        checkOutput("midrst_a",        32'(a),        32'd0);
        repeat (6) applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst_no_write", 32'(wrAddr.size()), 32'd0);
        sendSample(0, 6);
        checkOutput("midrst_next_a", 32'(wrAt(0)), 32'h00);

        // Randomized traffic against the model
        resetDut();
        for (int n = 0; n < 2500; n++) begin
            for (int c = 0; c < NCH; c++) df[c] = ($urandom_range(0, 5) == 0);
            gnt = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 399) == 0);
            applyStimulus(df, gnt, clr, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
